wb_master_if: RTL and testbench

- Single-transfer Wishbone B4 classic-cycle master engine.
- Turns a one-cycle `start` request from local logic (the DAQ path) into exactly one Wishbone read or write on the bus matrix master port.
- Returns read data and a busy indication.
- Sits between DSP/DAQ control logic and the shared bus matrix, where RAM slaves live.

---
 rtl/wb_master_pkg.sv | 18 +
 rtl/wb_master_if.sv | 165 ++++++++++++++++
 tb/tb_wb_master_if.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared types and constants for the Wishbone classic-cycle
// master engine.
//   state_t     - engine state (IDLE, BUS, RETRY)
//   CTI_CLASSIC - cycle type identifier driven on wb_cti_o
//   BTE_LINEAR  - burst type extension driven on wb_bte_o
`timescale 1ns/1ps
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RETRY = 2'd2
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_master_if.sv
// wb_master_if: single-transfer Wishbone B4 classic-cycle master.
// A one-cycle start pulse from local logic becomes exactly one read or
// write on the bus. rty terminations are reissued up to RETRY_LIMIT times.
//
// Ports:
//   wb_clk, wb_rst    clock (rising edge), async active-high reset
//   wb_adr_o .. wb_bte_o   Wishbone master outputs (all registered)
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i   Wishbone slave responses
//   start, address, selection, write, data_wr   local request
//   data_rd           last successfully read data
//   active            transfer in progress (state BUS or RETRY)
//
// Handshake: the local side raises start for one cycle; it is accepted only
// while the engine is IDLE (active = 0) and is dropped otherwise. On the
// bus, cyc&stb is the master's valid; the slave ends the attempt with
// exactly one of ack/err/rty, priority ack > err > rty when several are
// seen on the same edge.
`timescale 1ns/1ps
module wb_master_if
  import wb_master_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RETRY_LIMIT = 4
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  output logic [DW-1:0]   data_rd,
  output logic            active,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i,
  input  logic            start,
  input  logic [AW-1:0]   address,
  input  logic [DW/8-1:0] selection,
  input  logic            write,
  input  logic [DW-1:0]   data_wr
);

  // +2 keeps the counter at least one bit wide even for RETRY_LIMIT = 0.
  localparam int CW = $clog2(RETRY_LIMIT + 2);

  state_t            state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              active_q, active_d;
  logic [DW-1:0]     data_rd_q, data_rd_d;
  logic [CW-1:0]     rty_cnt_q, rty_cnt_d;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
      data_rd_q <= '0;
      rty_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      active_q  <= active_d;
      data_rd_q <= data_rd_d;
      rty_cnt_q <= rty_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    active_d  = active_q;
    data_rd_d = data_rd_q;
    rty_cnt_d = rty_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          adr_d     = address;
          dat_d     = data_wr;
          sel_d     = selection;
          we_d      = write;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          active_d  = 1'b1;
          rty_cnt_d = '0;
          state_d   = BUS;
        end
      end

      BUS: begin
        if (wb_ack_i) begin
          if (!we_q) data_rd_d = wb_dat_i;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          active_d  = 1'b0;
          rty_cnt_d = '0;
          state_d   = IDLE;
        end else if (wb_err_i || (wb_rty_i && rty_cnt_q == CW'(RETRY_LIMIT))) begin
          // Error, or retries exhausted: abandon without touching data_rd.
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          active_d  = 1'b0;
          rty_cnt_d = '0;
          state_d   = IDLE;
        end else if (wb_rty_i) begin
          // Release the bus for one cycle; the latched request is kept.
          rty_cnt_d = rty_cnt_q + 1'b1;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          state_d   = RETRY;
        end
      end

      RETRY: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        state_d = BUS;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_cti_o = CTI_CLASSIC;
  assign wb_bte_o = BTE_LINEAR;
  assign data_rd  = data_rd_q;
  assign active   = active_q;

endmodule

// File: tb/tb_wb_master_if.sv
`timescale 1ns/1ps
module tb_wb_master_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 wb_clk = ~wb_clk;

  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [DW-1:0] data_rd;
  logic          active;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i, wb_err_i, wb_rty_i;
  logic          start = 1'b0;
  logic [AW-1:0] address = '0;
  logic [SW-1:0] selection = '0;
  logic          write = 1'b0;
  logic [DW-1:0] data_wr = '0;

  wb_master_if #(.AW(AW), .DW(DW), .RETRY_LIMIT(4)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .data_rd(data_rd), .active(active),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i),
    .start(start), .address(address), .selection(selection),
    .write(write), .data_wr(data_wr)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int gap_total = 0;
  logic [63:0] exp_q[$];   // expected {adr, dat} of every bus attempt

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- RAM slave model ----------------
  // Zero-wait-state RAM, 16 words. Knobs: stall holds off ack, err_mode
  // answers with err, rty_want rty answers are given per transfer.
  logic          stall = 1'b0;
  logic          err_mode = 1'b0;
  int            rty_want = 0;
  int            rty_seen;
  logic [DW-1:0] mem [16];
  logic          term;

  assign term     = wb_cyc_o && wb_stb_o;
  assign wb_rty_i = term && (rty_seen < rty_want);
  assign wb_err_i = term && err_mode && !wb_rty_i;
  assign wb_ack_i = term && !stall && !err_mode && !wb_rty_i;
  assign wb_dat_i = mem[wb_adr_o[5:2]];

  always @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      rty_seen <= 0;
    end else begin
      if (!active) rty_seen <= 0;
      else if (wb_rty_i) rty_seen <= rty_seen + 1;
      if (wb_ack_i && wb_we_o)
        for (int b = 0; b < SW; b++)
          if (wb_sel_o[b]) mem[wb_adr_o[5:2]][b*8 +: 8] <= wb_dat_o[b*8 +: 8];
    end
  end

  // ---------------- bus monitor ----------------
  always @(negedge wb_clk) begin
    if (active && !wb_cyc_o) gap_total++;
    if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i)) begin
      check("attempt_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("attempt_adr_dat", {wb_adr_o, wb_dat_o}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [AW-1:0] a, input logic [SW-1:0] s,
                       input logic w, input logic [DW-1:0] d);
    @(negedge wb_clk);
    address = a; selection = s; write = w; data_wr = d; start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int cycles);
    cycles = 0;
    while (active && cycles < max) begin
      @(negedge wb_clk);
      cycles++;
    end
    if (active) check("idle_timeout", 64'(active), 64'd0);
  endtask

  task automatic xfer(input string tag, input logic [AW-1:0] a, input logic [SW-1:0] s,
                      input logic w, input logic [DW-1:0] d,
                      input int attempts, input int exp_cycles);
    int c;
    int g0;
    for (int i = 0; i < attempts; i++) exp_q.push_back({a, d});
    g0 = gap_total;
    issue(a, s, w, d);
    check({tag, "_start"}, 64'({wb_cyc_o, wb_stb_o, wb_we_o, active}),
          64'({1'b1, 1'b1, w, 1'b1}));
    wait_idle(64, c);
    check({tag, "_len"}, 64'(c), 64'(exp_cycles));
    check({tag, "_gaps"}, 64'(gap_total - g0), 64'(attempts - 1));
    check({tag, "_bus_free"}, 64'({wb_cyc_o, wb_stb_o, wb_we_o, active}), 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) @(negedge wb_clk);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_dat_sel_we", 64'({wb_dat_o, wb_sel_o, wb_we_o}), 64'd0);
    check("rst_cyc_stb_act", 64'({wb_cyc_o, wb_stb_o, active}), 64'd0);
    check("rst_data_rd", 64'(data_rd), 64'd0);
    check("rst_cti_bte", 64'({wb_cti_o, wb_bte_o}), 64'd0);
    wb_rst = 1'b0;

    // write then read, zero wait states
    xfer("wr_full", 32'h10, 4'hF, 1'b1, 32'hDEADBEEF, 1, 1);
    xfer("rd_full", 32'h10, 4'hF, 1'b0, 32'h0, 1, 1);
    check("rd_full_data", 64'(data_rd), 64'hDEADBEEF);

    // byte select
    xfer("wr_byte", 32'h10, 4'h1, 1'b1, 32'h000000AA, 1, 1);
    xfer("rd_byte", 32'h10, 4'hF, 1'b0, 32'h0, 1, 1);
    check("rd_byte_data", 64'(data_rd), 64'hDEADBEAA);

    // error keeps data_rd
    err_mode = 1'b1;
    xfer("rd_err", 32'h10, 4'hF, 1'b0, 32'h0, 1, 1);
    check("rd_err_data", 64'(data_rd), 64'hDEADBEAA);
    err_mode = 1'b0;

    // two retries then ack on a write
    rty_want = 2;
    xfer("wr_rty2", 32'h14, 4'hF, 1'b1, 32'h12345678, 3, 5);
    rty_want = 0;
    xfer("rd_rty2", 32'h14, 4'hF, 1'b0, 32'h0, 1, 1);
    check("rd_rty2_data", 64'(data_rd), 64'h12345678);

    // five retries: abandoned after the fifth
    rty_want = 5;
    xfer("rd_rty5", 32'h14, 4'hF, 1'b0, 32'h0, 5, 9);
    check("rd_rty5_data", 64'(data_rd), 64'h12345678);

    // four retries then ack: counter must have restarted from zero
    rty_want = 4;
    xfer("rd_rty4", 32'h10, 4'hF, 1'b0, 32'h0, 5, 9);
    check("rd_rty4_data", 64'(data_rd), 64'hDEADBEAA);
    rty_want = 0;

    // busy rejection and start on the completing edge
    stall = 1'b1;
    exp_q.push_back({32'h14, 32'h0});
    issue(32'h14, 4'hF, 1'b0, 32'h0);
    address = 32'h20; start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0;
    check("busy_adr", 64'(wb_adr_o), 64'h14);
    check("busy_active", 64'({wb_cyc_o, active}), 64'b11);
    stall = 1'b0;
    address = 32'h24; start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0;
    check("busy_done", 64'({wb_cyc_o, wb_stb_o, active}), 64'd0);
    check("busy_data", 64'(data_rd), 64'h12345678);
    @(negedge wb_clk);
    check("busy_no_restart", 64'({wb_cyc_o, active}), 64'd0);

    // reset mid-transfer is immediate
    stall = 1'b1;
    issue(32'h10, 4'hF, 1'b0, 32'h0);
    check("rst_mid_busy", 64'({wb_cyc_o, wb_stb_o, active}), 64'b111);
    #3;
    wb_rst = 1'b1;
    #1;
    check("rst_mid_bus", 64'({wb_cyc_o, wb_stb_o, active}), 64'd0);
    check("rst_mid_data", 64'(data_rd), 64'd0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge wb_clk);
    check("rst_mid_stays_idle", 64'({wb_cyc_o, active}), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
